mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; it SHALL be asynchronous and active-high.
REQ-004 The block SHALL have port Start, input, 1, a request pulse that is sampled on the rising edge.
REQ-005 The block SHALL have port Funct3, input, 3, selecting the operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have port Op1, input, WIDTH, the first operand (multiplicand or dividend), taken from the ALU operand selector.
REQ-007 The block SHALL have port Op2, input, WIDTH, the second operand (multiplier or divisor), taken from the ALU operand selector.
REQ-008 The block SHALL have port Result, output, WIDTH, the registered result.
REQ-009 The block SHALL have port Busy, output, 1, high while an operation is iterating.
REQ-010 The block SHALL have port Done, output, 1, a one-cycle pulse marking Result valid.

Function
REQ-011 The block SHALL implement three states: IDLE, CALC and DONE; Busy SHALL be 1 only in CALC, and Done SHALL be 1 only in DONE.
REQ-012 Start SHALL be accepted only when Busy is 0 (IDLE or DONE); Start during CALC SHALL be ignored with no effect on state or result.
REQ-013 On acceptance, Op1, Op2 and Funct3 SHALL be latched; later changes to the inputs SHALL NOT affect the operation in flight.
REQ-014 On a normal acceptance, the state SHALL go to CALC with an iteration counter of 0.
REQ-015 CALC SHALL last exactly WIDTH cycles, with one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
REQ-016 After the last CALC cycle the state SHALL go to DONE, so Done is seen WIDTH+1 rising edges after the accepting edge (33 for WIDTH=32).
REQ-017 Result SHALL be written on entry to DONE and held until the next accepted operation completes.
REQ-018 DONE SHALL last one cycle, then go to IDLE, or to CALC if Start is present in that cycle (back-to-back).
REQ-019 Multiply SHALL form the full 2*WIDTH product on operand magnitudes, then negate it if the required sign is negative.
REQ-020 Multiply signedness SHALL be: MULH signed x signed, MULHSU signed Op1 x unsigned Op2, MULHU unsigned x unsigned, MUL any (low half only).
REQ-021 MUL SHALL return the low WIDTH bits of the product; MULH, MULHSU and MULHU SHALL return the high WIDTH bits.
REQ-022 Signed divide SHALL operate on operand magnitudes; the quotient SHALL be negative iff the operand signs differ, and the remainder SHALL take the sign of the dividend (truncating division).
REQ-023 DIVU and REMU SHALL be fully unsigned.
REQ-024 Divide by zero SHALL be detected at acceptance and SHALL go directly to DONE, so Done appears on the next edge.
REQ-025 On divide by zero, DIV and DIVU SHALL return all ones, and REM and REMU SHALL return Op1.
REQ-026 Signed overflow (Op1 = 0x80000000, Op2 = 0xFFFFFFFF, DIV or REM) SHALL go directly to DONE.
REQ-027 On signed overflow, DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-028 No exception or flag output SHALL exist; the special cases SHALL be signalled only through Result.
REQ-029 All arithmetic SHALL be modulo 2^WIDTH on Result, and negation of 0x80000000 SHALL wrap to itself.

Reset
REQ-030 While rst is 1, the state SHALL be IDLE, the counter 0, Result 0, Busy 0 and Done 0, with no clock edge required.
REQ-031 Reset asserted mid-CALC SHALL abandon the operation, and no Done SHALL follow for it.
REQ-032 After rst deasserts, the first rising edge with Start=1 SHALL be accepted.

Verification
REQ-033 The bench SHALL cover: MUL, Op1=7, Op2=0xFFFFFFFD -> Busy for 32 cycles, Done at edge 33, Result=0xFFFFFFEB.
REQ-034 The bench SHALL cover: MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU, 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-035 The bench SHALL cover: DIV, 0xFFFFFFEC / 3 -> 0xFFFFFFFA; REM with the same operands -> 0xFFFFFFFE; DIVU, 100 / 7 -> 14; REMU, 100 / 7 -> 2.
REQ-036 The bench SHALL cover: DIVU, 100 / 0 -> 0xFFFFFFFF with Done one edge after Start; REM, 0x12345678 / 0 -> 0x12345678.
REQ-037 The bench SHALL cover: DIV, 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; both with a one-edge latency.
REQ-038 The bench SHALL cover: Start pulsed at CALC cycle 5 with different operands -> ignored and the original result delivered.
REQ-039 The bench SHALL cover: rst pulsed at CALC cycle 10 -> Busy=0, Done=0, Result=0 immediately, and a new MUL 3 x 4 then returns 12.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// One shift-add or restoring shift-subtract step per cycle.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] Op1,
   input  logic [WIDTH-1:0] Op2,
   output logic [WIDTH-1:0] Result,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_REM    = 3'b110;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state, state_n;

   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] hi, hi_n;
   logic [WIDTH-1:0] lo, lo_n;
   logic [WIDTH-1:0] opb, opb_n;
   logic [2:0]       fn, fn_n;
   logic             neg, neg_n;
   logic [WIDTH-1:0] res, res_n;

   logic             s1, s2;
   logic [WIDTH-1:0] mag1, mag2;
   logic             div_zero, ovf;
   logic [WIDTH-1:0] special;
   logic             acc_neg;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rsh;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] step_hi, step_lo;

   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quo, rem;
   logic [WIDTH-1:0]   final_res;

   assign Busy   = (state == CALC);
   assign Done   = (state == DONE);
   assign Result = res;

   // Decode incoming operands: signs, magnitudes and the early-exit cases.
   always_comb begin
      s1 = 1'b0;
      s2 = 1'b0;
      unique case (1'b1)
         (Funct3 == F_MULH),
         (Funct3 == F_DIV),
         (Funct3 == F_REM): begin
            s1 = Op1[WIDTH-1];
            s2 = Op2[WIDTH-1];
         end
         (Funct3 == F_MULHSU): begin
            s1 = Op1[WIDTH-1];
         end
         default: ;
      endcase
      mag1 = s1 ? -Op1 : Op1;
      mag2 = s2 ? -Op2 : Op2;
      acc_neg = (Funct3[2] && Funct3[1]) ? s1 : (s1 ^ s2);
      div_zero = Funct3[2] && (Op2 == '0);
      ovf = ((Funct3 == F_DIV) || (Funct3 == F_REM))
            && (Op1 == MIN) && (Op2 == '1);
      special = '0;
      if (div_zero)
         special = Funct3[1] ? Op1 : '1;
      else if (ovf)
         special = Funct3[1] ? '0 : MIN;
   end

   // One iteration step: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      rsh  = {hi, lo[WIDTH-1]};
      diff = rsh - {1'b0, opb};
      if (!fn[2]) begin
         step_hi = sum[WIDTH:1];
         step_lo = {sum[0], lo[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
         step_hi = diff[WIDTH-1:0];
         step_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
         step_hi = rsh[WIDTH-1:0];
         step_lo = {lo[WIDTH-2:0], 1'b0};
      end
   end

   // Apply the result sign and pick the half or quotient/remainder.
   always_comb begin
      prod   = {step_hi, step_lo};
      prod_s = neg ? -prod : prod;
      quo    = neg ? -step_lo : step_lo;
      rem    = neg ? -step_hi : step_hi;
      if (fn[2])
         final_res = fn[1] ? rem : quo;
      else if (fn == F_MUL)
         final_res = prod_s[WIDTH-1:0];
      else
         final_res = prod_s[2*WIDTH-1:WIDTH];
   end

   // Next-state logic and datapath loads for IDLE/CALC/DONE.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      hi_n    = hi;
      lo_n    = lo;
      opb_n   = opb;
      fn_n    = fn;
      neg_n   = neg;
      res_n   = res;
      unique case (state)
         IDLE, DONE: begin
            state_n = IDLE;
            if (Start) begin
               fn_n  = Funct3;
               neg_n = acc_neg;
               cnt_n = '0;
               hi_n  = '0;
               lo_n  = Funct3[2] ? mag1 : mag2;
               opb_n = Funct3[2] ? mag2 : mag1;
               if (div_zero || ovf) begin
                  state_n = DONE;
                  res_n   = special;
               end else begin
                  state_n = CALC;
               end
            end
         end
         CALC: begin
            hi_n = step_hi;
            lo_n = step_lo;
            if (cnt == LAST) begin
               state_n = DONE;
               res_n   = final_res;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, counter and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         opb   <= '0;
         fn    <= '0;
         neg   <= 1'b0;
         res   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         hi    <= hi_n;
         lo    <= lo_n;
         opb   <= opb_n;
         fn    <= fn_n;
         neg   <= neg_n;
         res   <= res_n;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit.
// Edges are counted with the accepting edge as edge 1.
module tb_mul_div_unit;

   logic        clk;
   logic        rst;
   logic        Start;
   logic [2:0]  Funct3;
   logic [31:0] Op1;
   logic [31:0] Op2;
   logic [31:0] Result;
   logic        Busy;
   logic        Done;

   int pass_cnt = 0;
   int total    = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .Start  (Start),
      .Funct3 (Funct3),
      .Op1    (Op1),
      .Op2    (Op2),
      .Result (Result),
      .Busy   (Busy),
      .Done   (Done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic start_op(input logic [2:0] f,
                           input logic [31:0] a,
                           input logic [31:0] b);
      @(negedge clk);
      Start  = 1'b1;
      Funct3 = f;
      Op1    = a;
      Op2    = b;
      @(posedge clk);
      #1;
      Start = 1'b0;
   endtask

   task automatic wait_done(input int first, output int edges,
                            output int busy_n);
      edges  = first;
      busy_n = Busy ? 1 : 0;
      while (!Done && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
         if (Busy) busy_n++;
      end
   endtask

   task automatic test_reset;
      rst    = 1'b1;
      Start  = 1'b0;
      Funct3 = 3'b000;
      Op1    = '0;
      Op2    = '0;
      #3;
      total++;
      if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy);
      else pass_cnt++;
      total++;
      if (Done !== 1'b0) $display("FAIL reset_done got %b want 0", Done);
      else pass_cnt++;
      total++;
      if (Result !== 32'h0)
         $display("FAIL reset_result got %h want 0", Result);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_mul;
      int e, b;
      logic [31:0] held;
      start_op(3'b000, 32'd7, 32'hFFFFFFFD);
      wait_done(1, e, b);
      total++;
      if (e !== 33) $display("FAIL mul_latency got %0d want 33", e);
      else pass_cnt++;
      total++;
      if (b !== 32) $display("FAIL mul_busy_cycles got %0d want 32", b);
      else pass_cnt++;
      total++;
      if (Result !== 32'hFFFFFFEB)
         $display("FAIL mul_result got %h want FFFFFFEB", Result);
      else pass_cnt++;
      held = Result;
      @(posedge clk);
      #1;
      total++;
      if (Done !== 1'b0) $display("FAIL mul_done_pulse got %b want 0", Done);
      else pass_cnt++;
      total++;
      if (Result !== 32'hFFFFFFEB)
         $display("FAIL mul_result_hold got %h want %h", Result, held);
      else pass_cnt++;
   endtask

   task automatic test_mulh;
      int e, b;
      start_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'hFFFFFFFE)
         $display("FAIL mulhu got %h want FFFFFFFE", Result);
      else pass_cnt++;
      start_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'h0) $display("FAIL mulh got %h want 0", Result);
      else pass_cnt++;
      start_op(3'b010, 32'hFFFFFFFF, 32'h2);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'hFFFFFFFF)
         $display("FAIL mulhsu got %h want FFFFFFFF", Result);
      else pass_cnt++;
      total++;
      if (e !== 33) $display("FAIL mulhsu_latency got %0d want 33", e);
      else pass_cnt++;
   endtask

   task automatic test_div;
      int e, b;
      start_op(3'b100, 32'hFFFFFFEC, 32'd3);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'hFFFFFFFA)
         $display("FAIL div got %h want FFFFFFFA", Result);
      else pass_cnt++;
      total++;
      if (e !== 33) $display("FAIL div_latency got %0d want 33", e);
      else pass_cnt++;
      start_op(3'b110, 32'hFFFFFFEC, 32'd3);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'hFFFFFFFE)
         $display("FAIL rem got %h want FFFFFFFE", Result);
      else pass_cnt++;
      start_op(3'b101, 32'd100, 32'd7);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'd14) $display("FAIL divu got %h want 0000000e", Result);
      else pass_cnt++;
      start_op(3'b111, 32'd100, 32'd7);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'd2) $display("FAIL remu got %h want 00000002", Result);
      else pass_cnt++;
   endtask

   task automatic test_div_zero;
      int e, b;
      start_op(3'b101, 32'd100, 32'd0);
      wait_done(1, e, b);
      total++;
      if (e !== 1) $display("FAIL divu0_latency got %0d want 1", e);
      else pass_cnt++;
      total++;
      if (b !== 0) $display("FAIL divu0_busy got %0d want 0", b);
      else pass_cnt++;
      total++;
      if (Result !== 32'hFFFFFFFF)
         $display("FAIL divu0 got %h want FFFFFFFF", Result);
      else pass_cnt++;
      start_op(3'b110, 32'h12345678, 32'd0);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'h12345678)
         $display("FAIL rem0 got %h want 12345678", Result);
      else pass_cnt++;
      total++;
      if (e !== 1) $display("FAIL rem0_latency got %0d want 1", e);
      else pass_cnt++;
   endtask

   task automatic test_overflow;
      int e, b;
      start_op(3'b100, 32'h80000000, 32'hFFFFFFFF);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'h80000000)
         $display("FAIL div_ovf got %h want 80000000", Result);
      else pass_cnt++;
      total++;
      if (e !== 1) $display("FAIL div_ovf_latency got %0d want 1", e);
      else pass_cnt++;
      start_op(3'b110, 32'h80000000, 32'hFFFFFFFF);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'h0) $display("FAIL rem_ovf got %h want 0", Result);
      else pass_cnt++;
      total++;
      if (e !== 1) $display("FAIL rem_ovf_latency got %0d want 1", e);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      int e, b;
      start_op(3'b011, 32'h80000000, 32'd4);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'h2) $display("FAIL b2b_first got %h want 2", Result);
      else pass_cnt++;
      start_op(3'b000, 32'h00012345, 32'h10);
      total++;
      if (Busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", Busy);
      else pass_cnt++;
      total++;
      if (Result !== 32'h2)
         $display("FAIL b2b_hold got %h want 2", Result);
      else pass_cnt++;
      wait_done(1, e, b);
      total++;
      if (Result !== 32'h00123450)
         $display("FAIL b2b_second got %h want 00123450", Result);
      else pass_cnt++;
      total++;
      if (e !== 33) $display("FAIL b2b_latency got %0d want 33", e);
      else pass_cnt++;
   endtask

   task automatic test_ignore_start;
      int e, b;
      start_op(3'b101, 32'd100, 32'd7);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      Start  = 1'b1;
      Funct3 = 3'b000;
      Op1    = 32'd3;
      Op2    = 32'd4;
      @(posedge clk);
      #1;
      Start = 1'b0;
      wait_done(6, e, b);
      total++;
      if (e !== 33) $display("FAIL ign_latency got %0d want 33", e);
      else pass_cnt++;
      total++;
      if (Result !== 32'd14)
         $display("FAIL ign_result got %h want 0000000e", Result);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total++;
      if (Busy !== 1'b0 || Done !== 1'b0)
         $display("FAIL ign_idle got busy=%b done=%b want 0 0", Busy, Done);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_calc;
      int e, b;
      bit seen;
      start_op(3'b000, 32'h0000FFFF, 32'h0000FFFF);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (Busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", Busy);
      else pass_cnt++;
      total++;
      if (Done !== 1'b0) $display("FAIL rstmid_done got %b want 0", Done);
      else pass_cnt++;
      total++;
      if (Result !== 32'h0)
         $display("FAIL rstmid_result got %h want 0", Result);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (Done) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) $display("FAIL rstmid_no_done got %b want 0", seen);
      else pass_cnt++;
      start_op(3'b000, 32'd3, 32'd4);
      wait_done(1, e, b);
      total++;
      if (Result !== 32'd12)
         $display("FAIL rstmid_mul got %h want 0000000c", Result);
      else pass_cnt++;
      total++;
      if (e !== 33) $display("FAIL rstmid_latency got %0d want 33", e);
      else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_mul;
      test_mulh;
      test_div;
      test_div_zero;
      test_overflow;
      test_back_to_back;
      test_ignore_start;
      test_reset_mid_calc;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
